spinn_pkt_arb: RTL
==================

Name: spinn_pkt_arb

Overview:
- Round-robin arbiter that shares the single outbound SpiNNaker link packet port (the spinn_driver pkt_data/pkt_vld/pkt_rdy input) between NREQ packet sources, such as the in_mapper, a config/command injector and test generators.
- Provides a one-entry registered output stage, a per-source enable mask and per-source grant counters.
- Sits between the packet producers and spinn_driver in the clk_mod domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PKT_W, 72, packet width: 8-bit header, 32-bit key and 32-bit optional payload.
- CNT_W, 16, width of each grant counter.

Ports:
- clk  in  1  module clock (clk_mod).
- rst  in  1  reset, asynchronous, active-low.
- req_data  in  NREQ*PKT_W  packet from requester i, in bits [i*PKT_W +: PKT_W].
- req_vld  in  NREQ  requester i has a packet.
- req_rdy  out  NREQ  requester i's packet is accepted this cycle.
- cfg_en  in  NREQ  requester i is eligible for grant.
- pkt_data  out  PKT_W  packet to spinn_driver.
- pkt_vld  out  1  pkt_data is valid.
- pkt_rdy  in  1  spinn_driver accepts the packet.
- grant_id  out  $clog2(NREQ)  source index of the packet currently held in pkt_data.
- cnt_sel  in  $clog2(NREQ)  selects which grant counter is read.
- cnt_val  out  CNT_W  grant count of requester cnt_sel (combinational mux of registers).
- cnt_clr  in  1  synchronous clear of all grant counters.

Behaviour:
- Reset (rst=0, async):
  - pkt_vld=0, pkt_data=0, grant_id=0, rr_ptr=0, all counters=0.
  - req_rdy=0 throughout reset.
- Output stage states:
  - EMPTY: pkt_vld=0.
  - FULL: pkt_vld=1.
  - load = (state==EMPTY || pkt_rdy) && any_elig.
- Eligibility and selection:
  - elig[i] = req_vld[i] & cfg_en[i].
  - Winner w = first set elig bit searching upward from rr_ptr, wrapping modulo NREQ.
- Accept (load=1):
  - req_rdy[w]=1 in the same cycle; req_rdy is combinational from elig, rr_ptr and state. Only one req_rdy bit is ever high.
  - Next edge: pkt_data<=req_data[w], grant_id<=w, pkt_vld<=1, rr_ptr<=(w+1) mod NREQ, cnt[w]<=cnt[w]+1 (wraps at 2^CNT_W).
- Other transitions:
  - FULL & pkt_rdy & !any_elig -> EMPTY; pkt_vld<=0 and data is held.
  - FULL & !pkt_rdy -> hold. pkt_data and grant_id stay stable and req_rdy=0.
- Timing:
  - Latency: req_vld high with the stage EMPTY gives pkt_vld one cycle later.
  - Throughput: one packet per cycle when pkt_rdy is held high (back-to-back loads).
- No combinational path from pkt_rdy to pkt_vld or pkt_data. req_rdy does depend on pkt_rdy, which is permitted.
- rr_ptr changes only on accept. A single active requester is granted on every load.
- cfg_en changes affect the next selection only. A packet already in the output stage is always delivered.
- Requesters must hold req_vld and req_data until their req_rdy. Violations are not detected.
- Simultaneous cnt_clr and accept: the clear wins, so cnt[w]=0 (the increment is lost).
- Reset mid-transfer drops the held packet. The consumer sees pkt_vld fall asynchronously.

Decomposition:
- Package spinn_arb_pkg holds:
  - localparams PKT_W=72 and header field offsets (shared with in_mapper/out_mapper);
  - function idx_w(n) = $clog2(n), minimum 1.
- Sub-module spinn_rr_pick, purely combinational:
  - inputs: elig[NREQ], ptr.
  - outputs: any, win index, one-hot grant.
  - Reused by future multi-link schedulers.
- The top holds the output register, rr_ptr and counters.

Test Plan:
- Reset then idle: rst low, all req_vld=0 -> pkt_vld=0, req_rdy=0, cnt_val=0 for all cnt_sel.
- Single source: req_vld=4'b0100, key 0x0000_1234, pkt_rdy=1 -> req_rdy=4'b0100 the same cycle; next cycle pkt_vld=1, grant_id=2, pkt_data key 0x1234.
- Fairness: all four valid continuously, pkt_rdy=1, 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3, one per cycle; every cnt=2.
- Backpressure: pkt_rdy=0 for 5 cycles while FULL with grant_id=1 and four requests pending -> pkt_data/grant_id stable, req_rdy=0; pkt_rdy=1 -> next grant_id=2.
- Mask: cfg_en=4'b1011, all valid -> grants 0,1,3,0,…; requester 2 is never granted and req_rdy[2] stays 0.
- Counter wrap and clear: preload by 65536 grants on port 0 -> cnt_val=0; cnt_clr asserted together with an accept on port 0 -> cnt[0]=0. Also assert rst low while FULL -> pkt_vld=0 immediately.

Source files
------------

// File: rtl/spinn_arb_pkg.sv
// Shared definitions for the SpiNNaker link packet path: packet layout,
// output-stage states and index-width helper.
package spinn_arb_pkg;

    localparam int PKT_W   = 72;
    localparam int HDR_OFS = 0;
    localparam int HDR_W   = 8;
    localparam int KEY_OFS = 8;
    localparam int KEY_W   = 32;
    localparam int PLD_OFS = 40;
    localparam int PLD_W   = 32;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ostage_t;

    // Index width for n items; a single-bit field is kept even for n <= 2.
    function automatic int idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spinn_rr_pick.sv
// Combinational round-robin picker: first eligible index at or above i_ptr,
// wrapping modulo NREQ.
module spinn_rr_pick
    import spinn_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] i_elig,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_any,
    output logic [IW-1:0]   o_win,
    output logic [NREQ-1:0] o_gnt
);

    int w_idx;

    // Walk from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        o_win = '0;
        w_idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_idx = (int'(i_ptr) + k) % NREQ;
            if (i_elig[w_idx]) o_win = IW'(w_idx);
        end
    end

    assign o_any = |i_elig;
    assign o_gnt = o_any ? (NREQ'(1) << o_win) : '0;

endmodule

// File: rtl/spinn_pkt_arb.sv
// Round-robin arbiter feeding the spinn_driver packet port through a
// one-entry registered output stage, with per-source grant counters.
//   state    | meaning
//   ST_EMPTY | output stage holds nothing, pkt_vld=0
//   ST_FULL  | output stage holds a packet for spinn_driver, pkt_vld=1
module spinn_pkt_arb
    import spinn_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int PKT_W = spinn_arb_pkg::PKT_W,
    parameter  int CNT_W = 16,
    localparam int IW    = idx_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ*PKT_W-1:0] req_data,
    input  logic [NREQ-1:0]       req_vld,
    output logic [NREQ-1:0]       req_rdy,
    input  logic [NREQ-1:0]       cfg_en,
    output logic [PKT_W-1:0]      pkt_data,
    output logic                  pkt_vld,
    input  logic                  pkt_rdy,
    output logic [IW-1:0]         grant_id,
    input  logic [IW-1:0]         cnt_sel,
    output logic [CNT_W-1:0]      cnt_val,
    input  logic                  cnt_clr
);

    ostage_t          r_state;
    logic [PKT_W-1:0] r_data;
    logic [IW-1:0]    r_gid;
    logic [IW-1:0]    r_ptr;
    logic [CNT_W-1:0] r_cnt [NREQ];

    logic [NREQ-1:0]  w_elig;
    logic [NREQ-1:0]  w_gnt;
    logic [IW-1:0]    w_win;
    logic             w_any;
    logic             w_load;

    assign w_elig = req_vld & cfg_en;

    spinn_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_any  (w_any),
        .o_win  (w_win),
        .o_gnt  (w_gnt)
    );

    assign w_load = ((r_state == ST_EMPTY) || pkt_rdy) && w_any;

    // Gated by rst so no requester sees an accept while the stage is held in reset.
    assign req_rdy = (w_load && rst) ? w_gnt : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_gid   <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_load) begin
                        r_state <= ST_FULL;
                        r_data  <= req_data[w_win*PKT_W +: PKT_W];
                        r_gid   <= w_win;
                        r_ptr   <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_load) begin
                        r_data  <= req_data[w_win*PKT_W +: PKT_W];
                        r_gid   <= w_win;
                        r_ptr   <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
                    end else if (pkt_rdy) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    // A clear coinciding with an accept drops that accept's increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
        end else if (cnt_clr) begin
            for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
        end else if (w_load) begin
            r_cnt[w_win] <= r_cnt[w_win] + 1'b1;
        end
    end

    assign pkt_vld  = (r_state == ST_FULL);
    assign pkt_data = r_data;
    assign grant_id = r_gid;
    assign cnt_val  = (int'(cnt_sel) < NREQ) ? r_cnt[cnt_sel] : '0;

endmodule
